// File: rtl/prog_loader_if.sv
// Boot loader bus bundle: inbound byte stream (valid/ready) plus the
// outbound RAM program-write port and the loader status flags.
//   in_valid/in_data  : stream byte offered by the source
//   in_ready          : loader accepts a byte this cycle
//   prog_addr/wdata/we: RAM word write (one-cycle strobe)
//   prog_loading_done : image loaded and verified (sticky)
//   load_error        : bad length or checksum (sticky)
// master = the loader (drives RAM port), slave = stream source / RAM side.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;
    logic        prog_we;
    logic        prog_loading_done;
    logic        load_error;

    modport master (
        input  in_valid, in_data,
        output in_ready, prog_addr, prog_wdata, prog_we, prog_loading_done, load_error
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, prog_addr, prog_wdata, prog_we, prog_loading_done, load_error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Parses a byte stream framed as
// {len[31:0] LE, len payload bytes, 1 checksum byte}, packs the payload
// little-endian into 32-bit words and writes them upward from BASE_ADDR.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : prog_loader_if.master (stream in, RAM write out, status)
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_BYTES = 32'd65536
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.master bus
);
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t      state_q;
    logic [31:0] len_q;      // length shift register
    logic [31:0] rem_q;      // payload bytes still to come
    logic [31:0] widx_q;     // next word index
    logic [31:0] wbuf_q;     // partial word, unfilled lanes kept at 0
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  len_cnt_q, lane_q;
    logic [7:0]  sum_q;
    logic        we_q, done_q, err_q;

    logic        accept;
    logic        last_byte;
    logic [31:0] len_d, wbuf_d, addr_d;

    assign bus.in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept       = bus.in_valid && bus.in_ready;

    assign len_d     = {bus.in_data, len_q[31:8]};
    assign wbuf_d    = wbuf_q | ({24'd0, bus.in_data} << {lane_q, 3'b000});
    assign addr_d    = BASE_ADDR + {widx_q[29:0], 2'b00};
    assign last_byte = (rem_q == 32'd1);

    assign bus.prog_addr         = addr_q;
    assign bus.prog_wdata        = wdata_q;
    assign bus.prog_we           = we_q;
    assign bus.prog_loading_done = done_q;
    assign bus.load_error        = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_LEN;
            len_q     <= '0;
            rem_q     <= '0;
            widx_q    <= '0;
            wbuf_q    <= '0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            len_cnt_q <= '0;
            lane_q    <= '0;
            sum_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_LEN: if (accept) begin
                    len_q     <= len_d;
                    len_cnt_q <= len_cnt_q + 2'd1;
                    if (len_cnt_q == 2'd3) begin
                        rem_q <= len_d;
                        if (len_d > MAX_BYTES) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (len_d == 32'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: if (accept) begin
                    sum_q <= sum_q + bus.in_data;
                    rem_q <= rem_q - 32'd1;
                    if (lane_q == 2'd3 || last_byte) begin
                        // Buffer was cleared after the last emit, so lanes above
                        // the current one are already zero for a short tail word.
                        we_q    <= 1'b1;
                        addr_q  <= addr_d;
                        wdata_q <= wbuf_d;
                        widx_q  <= widx_q + 32'd1;
                        wbuf_q  <= '0;
                        lane_q  <= '0;
                    end else begin
                        wbuf_q <= wbuf_d;
                        lane_q <= lane_q + 2'd1;
                    end
                    if (last_byte) state_q <= S_CSUM;
                end
                S_CSUM: if (accept) begin
                    if (bus.in_data == sum_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: ;
                S_ERR:  ;
                default: state_q <= S_ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] MAXB = 32'd65536;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if bus();
    prog_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];     // {addr, data} of expected writes
    logic [7:0]  pl[$];        // payload of the image being sent
    bit          gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {addr,data}
    always @(negedge clk) begin
        if (rst_n && bus.prog_we) begin
            logic [63:0] e;
            vectors++;
            if (bus.prog_loading_done || bus.load_error) begin
                miscompares++;
                $display("FAIL we_with_status: prog_we=1 done=%0b err=%0b want no write", bus.prog_loading_done, bus.load_error);
            end
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h want none", bus.prog_addr, bus.prog_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.prog_addr !== e[63:32] || bus.prog_wdata !== e[31:0]) begin
                    miscompares++;
                    $display("FAIL write: got 0x%08h@0x%08h want 0x%08h@0x%08h",
                             bus.prog_wdata, bus.prog_addr, e[31:0], e[63:32]);
                end
            end
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        check("rst_addr",  bus.prog_addr, BASE);
        check("rst_wdata", bus.prog_wdata, 32'd0);
        check("rst_we",    {31'd0, bus.prog_we}, 32'd0);
        check("rst_done",  {31'd0, bus.prog_loading_done}, 32'd0);
        check("rst_err",   {31'd0, bus.load_error}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: in_ready=0 after %0d cycles want 1", t);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    // Reference model: expected words/addresses and verdict from the frame rules
    task automatic run_image(input logic [31:0] len, input logic [7:0] csum);
        logic [7:0]  s = 8'd0;
        logic [31:0] w;
        bit          ok;
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
        if (len > MAXB) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < pl.size(); i++) s += pl[i];
            for (int wi = 0; wi < (pl.size() + 3) / 4; wi++) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++)
                    if (4 * wi + j < pl.size()) w[8*j +: 8] = pl[4*wi + j];
                exp_q.push_back({BASE + 32'(4 * wi), w});
            end
            for (int i = 0; i < pl.size(); i++) send_byte(pl[i]);
            send_byte(csum);
            ok = (csum == s);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("done",    {31'd0, bus.prog_loading_done}, {31'd0, ok});
        check("error",   {31'd0, bus.load_error}, {31'd0, !ok});
        check("ready",   {31'd0, bus.in_ready}, 32'd0);
        check("pending", exp_q.size(), 32'd0);
        // trailing bytes must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("done_sticky", {31'd0, bus.prog_loading_done}, {31'd0, ok});
        check("err_sticky",  {31'd0, bus.load_error}, {31'd0, !ok});
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] s;
        int         n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        do_reset();
        check_reset_state();

        // 1
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_image(32'd8, 8'h64);
        // 2
        do_reset();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_image(32'd5, 8'h0F);
        // 3
        do_reset(); pl = {}; run_image(32'd0, 8'h00);
        do_reset(); pl = {}; run_image(32'd0, 8'h01);
        // 4
        do_reset(); pl = {}; run_image(32'h0001_0001, 8'h00);
        // 5
        do_reset();
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image(32'd4, 8'h00);
        // 6: abort mid-payload, then full image with and without gaps
        for (int g = 0; g < 2; g++) begin
            do_reset();
            gaps = (g == 1);
            send_byte(8'd8); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
            send_byte(8'h11); send_byte(8'h22);
            do_reset();
            check_reset_state();
            pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
            run_image(32'd8, 8'h64);
        end

        // randomized images
        for (int r = 0; r < 16; r++) begin
            do_reset();
            gaps = $urandom_range(0, 1) == 1;
            n = $urandom_range(0, 23);
            pl = {};
            s = 8'd0;
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom));
                s += pl[i];
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 + $urandom_range(0, 254));
            run_image(32'(n), s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
